// File: rtl/alpu_xbuf_mp.sv
// Multi-port consume-on-read tagged operand buffer for foreign (X) operands.
// Writes allocate lowest free entries; reads look up by tag with zero latency and may free the entry.
module alpu_xbuf_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 8,
    parameter int DEPTH      = 8,
    parameter int NUM_W      = 2,
    parameter int NUM_R      = 2,
    parameter int BYPASS     = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush_i,
    input  logic [NUM_W-1:0]              wvalid_i,
    output logic [NUM_W-1:0]              wready_o,
    input  logic [NUM_W*TAG_WIDTH-1:0]    wtag_i,
    input  logic [NUM_W*DATA_WIDTH-1:0]   wdata_i,
    input  logic [NUM_R-1:0]              rvalid_i,
    input  logic [NUM_R-1:0]              rconsume_i,
    input  logic [NUM_R*TAG_WIDTH-1:0]    rtag_i,
    output logic [NUM_R-1:0]              rhit_o,
    output logic [NUM_R*DATA_WIDTH-1:0]   rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          err_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [TAG_WIDTH-1:0]  tag_q  [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [CW-1:0]         count_q, count_d;
    logic                  err_q, err_d;
    logic [NUM_W-1:0]      wready_q, wready_d;
    logic                  full_q, empty_q;

    logic [NUM_W-1:0]      fire_s;
    logic [NUM_R-1:0]      shit_s, bhit_s;
    logic [IW-1:0]         sidx_s [NUM_R];
    logic [NUM_W-1:0]      bsel_s [NUM_R];
    logic [NUM_W-1:0]      aen_s;
    logic [IW-1:0]         aidx_s [NUM_W];

    // Lookup: lowest-index stored match wins; otherwise the lowest firing write may bypass.
    always_comb begin
        logic [TAG_WIDTH-1:0]  rt_v;
        logic [DATA_WIDTH-1:0] bd_v;
        logic [IW-1:0]         idx_v;
        logic [NUM_W-1:0]      bsel_v;
        logic                  hit_v, bhit_v, m_v, bm_v;
        fire_s  = wvalid_i & wready_q;
        rhit_o  = '0;
        rdata_o = '0;
        for (int j = 0; j < NUM_R; j++) begin
            rt_v   = rtag_i[j*TAG_WIDTH +: TAG_WIDTH];
            hit_v  = 1'b0;
            idx_v  = '0;
            bhit_v = 1'b0;
            bsel_v = '0;
            bd_v   = '0;
            for (int e = 0; e < DEPTH; e++) begin
                m_v   = valid_q[e] && (tag_q[e] == rt_v);
                idx_v = (m_v && !hit_v) ? IW'(e) : idx_v;
                hit_v = hit_v | m_v;
            end
            for (int i = 0; i < NUM_W; i++) begin
                bm_v      = (BYPASS != 0) && fire_s[i] && (wtag_i[i*TAG_WIDTH +: TAG_WIDTH] == rt_v);
                bsel_v[i] = bm_v && !bhit_v;
                bd_v      = (bm_v && !bhit_v) ? wdata_i[i*DATA_WIDTH +: DATA_WIDTH] : bd_v;
                bhit_v    = bhit_v | bm_v;
            end
            bhit_v    = bhit_v && !hit_v;
            shit_s[j] = hit_v;
            sidx_s[j] = idx_v;
            bhit_s[j] = bhit_v;
            bsel_s[j] = bsel_v;
            rhit_o[j] = rvalid_i[j] && (hit_v || bhit_v);
            rdata_o[j*DATA_WIDTH +: DATA_WIDTH] = !rvalid_i[j] ? '0 :
                                                  hit_v        ? data_q[idx_v] :
                                                  bhit_v       ? bd_v : '0;
        end
    end

    // Consume resolution, allocation, duplicate detection and next count.
    always_comb begin
        logic [DEPTH-1:0] free_v, taken_v, amask_v;
        logic [NUM_W-1:0] wcons_v;
        logic [IW-1:0]    aix_v;
        logic [CW-1:0]    nfree_v, nalloc_v;
        logic             cons_v, want_v, got_v, pick_v, dup_v;
        free_v  = '0;
        wcons_v = '0;
        for (int j = 0; j < NUM_R; j++) begin
            cons_v = rvalid_i[j] && rconsume_i[j];
            for (int e = 0; e < DEPTH; e++) begin
                free_v[e] = free_v[e] | (cons_v && shit_s[j] && (sidx_s[j] == IW'(e)));
            end
            wcons_v = wcons_v | ((cons_v && bhit_s[j]) ? bsel_s[j] : '0);
        end
        // Entries freed this cycle stay taken until the next cycle.
        taken_v = valid_q;
        amask_v = '0;
        for (int i = 0; i < NUM_W; i++) begin
            want_v = fire_s[i] && !wcons_v[i];
            got_v  = 1'b0;
            aix_v  = '0;
            for (int e = 0; e < DEPTH; e++) begin
                pick_v     = want_v && !got_v && !taken_v[e];
                aix_v      = pick_v ? IW'(e) : aix_v;
                got_v      = got_v | pick_v;
                taken_v[e] = taken_v[e] | pick_v;
                amask_v[e] = amask_v[e] | pick_v;
            end
            aen_s[i]  = got_v;
            aidx_s[i] = aix_v;
        end
        dup_v = 1'b0;
        for (int i = 0; i < NUM_W; i++) begin
            for (int e = 0; e < DEPTH; e++) begin
                dup_v = dup_v | (fire_s[i] && valid_q[e] && !free_v[e] &&
                                 (tag_q[e] == wtag_i[i*TAG_WIDTH +: TAG_WIDTH]));
            end
            for (int k = i + 1; k < NUM_W; k++) begin
                dup_v = dup_v | (fire_s[i] && fire_s[k] &&
                                 (wtag_i[i*TAG_WIDTH +: TAG_WIDTH] == wtag_i[k*TAG_WIDTH +: TAG_WIDTH]));
            end
        end
        nfree_v  = '0;
        nalloc_v = '0;
        for (int e = 0; e < DEPTH; e++) begin
            nfree_v  = nfree_v + CW'(free_v[e]);
            nalloc_v = nalloc_v + CW'(amask_v[e]);
        end
        count_d = count_q - nfree_v + nalloc_v;
        valid_d = (valid_q & ~free_v) | amask_v;
        err_d   = err_q | dup_v;
        for (int i = 0; i < NUM_W; i++) begin
            wready_d[i] = (int'(DEPTH) - int'(count_d)) > i;
        end
    end

    // Control state and status registers; flush clears exactly like reset.
    always_ff @(posedge clk) begin
        if (!reset_n || flush_i) begin
            valid_q  <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            wready_q <= '1;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            valid_q  <= valid_d;
            count_q  <= count_d;
            err_q    <= err_d;
            wready_q <= wready_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    // Payload storage carries no reset; valid_q alone qualifies it.
    always_ff @(posedge clk) begin
        if (reset_n && !flush_i) begin
            for (int i = 0; i < NUM_W; i++) begin
                if (aen_s[i]) begin
                    tag_q[aidx_s[i]]  <= wtag_i[i*TAG_WIDTH +: TAG_WIDTH];
                    data_q[aidx_s[i]] <= wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign wready_o = wready_q;
    assign count_o  = count_q;
    assign full_o   = full_q;
    assign empty_o  = empty_q;
    assign err_o    = err_q;
endmodule

// File: tb/tb_alpu_xbuf_mp.sv
// Scoreboard bench for alpu_xbuf_mp: a bypass instance (A) and a no-bypass instance (B) share stimulus.
module tb_alpu_xbuf_mp;
    localparam int DW = 32;
    localparam int TW = 8;
    localparam int D  = 8;
    localparam int NW = 2;
    localparam int NR = 2;
    localparam int CW = 4;

    localparam int S_RHIT0 = 0, S_RHIT1 = 1, S_RDATA0 = 2, S_RDATA1 = 3, S_COUNT = 4,
                   S_FULL = 5, S_EMPTY = 6, S_WREADY = 7, S_ERR = 8,
                   S_B_RHIT1 = 9, S_B_RDATA1 = 10, S_B_COUNT = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n, flush_i;
    logic [NW-1:0]     wvalid;
    logic [NW*TW-1:0]  wtag;
    logic [NW*DW-1:0]  wdata;
    logic [NR-1:0]     rvalid, rcons;
    logic [NR*TW-1:0]  rtag;

    logic [NW-1:0]     wready_a, wready_b;
    logic [NR-1:0]     rhit_a, rhit_b;
    logic [NR*DW-1:0]  rdata_a, rdata_b;
    logic [CW-1:0]     count_a, count_b;
    logic              full_a, full_b, empty_a, empty_b, err_a, err_b;

    alpu_xbuf_mp #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(D), .NUM_W(NW), .NUM_R(NR), .BYPASS(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .flush_i(flush_i),
        .wvalid_i(wvalid), .wready_o(wready_a), .wtag_i(wtag), .wdata_i(wdata),
        .rvalid_i(rvalid), .rconsume_i(rcons), .rtag_i(rtag),
        .rhit_o(rhit_a), .rdata_o(rdata_a), .count_o(count_a),
        .full_o(full_a), .empty_o(empty_a), .err_o(err_a)
    );

    alpu_xbuf_mp #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(D), .NUM_W(NW), .NUM_R(NR), .BYPASS(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .flush_i(flush_i),
        .wvalid_i(wvalid), .wready_o(wready_b), .wtag_i(wtag), .wdata_i(wdata),
        .rvalid_i(rvalid), .rconsume_i(rcons), .rtag_i(rtag),
        .rhit_o(rhit_b), .rdata_o(rdata_b), .count_o(count_b),
        .full_o(full_b), .empty_o(empty_b), .err_o(err_b)
    );

    typedef struct {
        int          cyc;
        int          sig;
        logic [63:0] exp;
        string       nm;
    } exp_t;

    exp_t sbq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] actual(input int sig);
        case (sig)
            S_RHIT0:    return 64'(rhit_a[0]);
            S_RHIT1:    return 64'(rhit_a[1]);
            S_RDATA0:   return 64'(rdata_a[31:0]);
            S_RDATA1:   return 64'(rdata_a[63:32]);
            S_COUNT:    return 64'(count_a);
            S_FULL:     return 64'(full_a);
            S_EMPTY:    return 64'(empty_a);
            S_WREADY:   return 64'(wready_a);
            S_ERR:      return 64'(err_a);
            S_B_RHIT1:  return 64'(rhit_b[1]);
            S_B_RDATA1: return 64'(rdata_b[63:32]);
            S_B_COUNT:  return 64'(count_b);
            default:    return 64'hDEAD_DEAD_DEAD_DEAD;
        endcase
    endfunction

    // Monitor: pops every expectation due this cycle and compares mid-cycle.
    always @(negedge clk) begin
        exp_t        it;
        logic [63:0] act;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            it  = sbq.pop_front();
            act = actual(it.sig);
            checks = checks + 1;
            if (act !== it.exp) begin
                errors = errors + 1;
                $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", it.nm, act, it.exp, cyc);
            end
        end
    end

    task automatic chk(input int sig, input logic [63:0] v, input string nm);
        exp_t it;
        it.cyc = cyc;
        it.sig = sig;
        it.exp = v;
        it.nm  = nm;
        sbq.push_back(it);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush_i = 1'b0;
        wvalid  = '0;
        wtag    = '0;
        wdata   = '0;
        rvalid  = '0;
        rcons   = '0;
        rtag    = '0;
    endtask

    task automatic wr(input int ch, input logic [TW-1:0] t, input logic [DW-1:0] d);
        wvalid[ch]          = 1'b1;
        wtag[ch*TW +: TW]   = t;
        wdata[ch*DW +: DW]  = d;
    endtask

    task automatic rd(input int p, input logic [TW-1:0] t, input logic c);
        rvalid[p]          = 1'b1;
        rcons[p]           = c;
        rtag[p*TW +: TW]   = t;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        idle();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        chk(S_COUNT, 64'd0, "rst_count");
        chk(S_EMPTY, 64'd1, "rst_empty");
        chk(S_FULL, 64'd0, "rst_full");
        chk(S_WREADY, 64'd3, "rst_wready");
        chk(S_ERR, 64'd0, "rst_err");
        wr(0, 8'h21, 32'hAAAA_0001);
        step();

        idle();
        rd(0, 8'h21, 1'b1);
        chk(S_RHIT0, 64'd1, "basic_hit");
        chk(S_RDATA0, 64'hAAAA_0001, "basic_data");
        chk(S_COUNT, 64'd1, "basic_count1");
        step();

        idle();
        rd(0, 8'h21, 1'b0);
        chk(S_RHIT0, 64'd0, "reread_miss");
        chk(S_RDATA0, 64'd0, "reread_data0");
        chk(S_COUNT, 64'd0, "consumed_count");
        chk(S_EMPTY, 64'd1, "consumed_empty");
        step();

        for (int k = 0; k < 4; k++) begin
            idle();
            wr(0, 8'(2*k), 32'h100 + 32'(2*k));
            wr(1, 8'(2*k+1), 32'h100 + 32'(2*k+1));
            chk(S_WREADY, 64'd3, "fill_wready");
            step();
        end

        idle();
        chk(S_FULL, 64'd1, "fill_full");
        chk(S_WREADY, 64'd0, "fill_wready0");
        chk(S_COUNT, 64'd8, "fill_count");
        rd(0, 8'h00, 1'b1);
        chk(S_RHIT0, 64'd1, "full_consume_hit");
        chk(S_RDATA0, 64'h100, "full_consume_data");
        step();

        idle();
        chk(S_WREADY, 64'd1, "one_free_wready");
        chk(S_COUNT, 64'd7, "one_free_count");
        chk(S_FULL, 64'd0, "one_free_notfull");
        wr(0, 8'h08, 32'h108);
        wr(1, 8'h09, 32'h109);
        step();

        idle();
        chk(S_COUNT, 64'd8, "refill_count");
        chk(S_FULL, 64'd1, "refill_full");
        chk(S_WREADY, 64'd0, "refill_wready");
        rd(1, 8'h08, 1'b0);
        rd(0, 8'h09, 1'b0);
        chk(S_RHIT1, 64'd1, "refill_hit08");
        chk(S_RDATA1, 64'h108, "refill_data08");
        chk(S_RHIT0, 64'd0, "refused_ch1_miss");
        flush_i = 1'b1;
        step();

        idle();
        chk(S_COUNT, 64'd0, "flush_count");
        chk(S_EMPTY, 64'd1, "flush_empty");
        chk(S_WREADY, 64'd3, "flush_wready");
        wr(1, 8'h33, 32'hBEEF_0033);
        rd(1, 8'h33, 1'b1);
        chk(S_RHIT1, 64'd1, "bypass_hit");
        chk(S_RDATA1, 64'hBEEF_0033, "bypass_data");
        chk(S_B_RHIT1, 64'd0, "nobypass_miss");
        chk(S_B_RDATA1, 64'd0, "nobypass_data0");
        step();

        idle();
        chk(S_COUNT, 64'd0, "bypass_count");
        chk(S_B_COUNT, 64'd1, "nobypass_count");
        flush_i = 1'b1;
        step();

        idle();
        chk(S_B_COUNT, 64'd0, "nobypass_flush");
        wr(0, 8'h10, 32'h1);
        wr(1, 8'h10, 32'h2);
        step();

        idle();
        chk(S_ERR, 64'd1, "dup_err");
        chk(S_COUNT, 64'd2, "dup_count");
        rd(0, 8'h10, 1'b0);
        chk(S_RHIT0, 64'd1, "dup_hit");
        chk(S_RDATA0, 64'h1, "dup_lowest_wins");
        flush_i = 1'b1;
        step();

        idle();
        chk(S_ERR, 64'd0, "flush_err");
        chk(S_COUNT, 64'd0, "flush_count2");
        wr(0, 8'h05, 32'h55);
        wr(1, 8'h04, 32'h44);
        step();

        idle();
        chk(S_COUNT, 64'd2, "pre_dual_count");
        rd(0, 8'h05, 1'b1);
        rd(1, 8'h05, 1'b1);
        wr(0, 8'h06, 32'h66);
        chk(S_RHIT0, 64'd1, "dual_hit0");
        chk(S_RHIT1, 64'd1, "dual_hit1");
        chk(S_RDATA0, 64'h55, "dual_data0");
        chk(S_RDATA1, 64'h55, "dual_data1");
        step();

        idle();
        chk(S_COUNT, 64'd2, "dual_net_count");
        chk(S_ERR, 64'd0, "dual_no_err");
        rd(0, 8'h05, 1'b0);
        rd(1, 8'h06, 1'b0);
        chk(S_RHIT0, 64'd0, "dual_freed_miss");
        chk(S_RHIT1, 64'd1, "dual_new_hit");
        chk(S_RDATA1, 64'h66, "dual_new_data");
        wr(1, 8'h04, 32'h99);
        step();

        idle();
        chk(S_ERR, 64'd1, "stored_dup_err");
        chk(S_COUNT, 64'd3, "stored_dup_count");
        flush_i = 1'b1;
        step();

        idle();
        chk(S_ERR, 64'd0, "flush_err2");
        wr(0, 8'h40, 32'h40);
        wr(1, 8'h41, 32'h41);
        step();
        idle();
        wr(0, 8'h42, 32'h42);
        wr(1, 8'h43, 32'h43);
        step();
        idle();
        chk(S_COUNT, 64'd4, "midfill_count4");
        wr(0, 8'h44, 32'h44);
        step();

        idle();
        chk(S_COUNT, 64'd5, "midfill_count5");
        reset_n = 1'b0;
        wr(0, 8'h50, 32'h50);
        wr(1, 8'h51, 32'h51);
        step();

        idle();
        reset_n = 1'b1;
        chk(S_COUNT, 64'd0, "midrst_count");
        chk(S_EMPTY, 64'd1, "midrst_empty");
        chk(S_FULL, 64'd0, "midrst_full");
        chk(S_WREADY, 64'd3, "midrst_wready");
        chk(S_ERR, 64'd0, "midrst_err");
        rd(0, 8'h50, 1'b0);
        chk(S_RHIT0, 64'd0, "midrst_discarded");
        step();

        idle();
        repeat (3) step();
        if (sbq.size() != 0) begin
            errors = errors + sbq.size();
            $display("FAIL scoreboard_drain: actual=%0d pending required=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
